e_calc: RTL and testbench

E_CALC -- requirements
Module: e_calc

---
 rtl/e_calc_pkg.sv | 29 ++
 rtl/e_calc_squarer.sv | 97 +++++++++
 rtl/e_calc.sv | 113 +++++++++++
 tb/tb_e_calc.sv | 133 +++++++++++++
 4 files changed

// File: rtl/e_calc_pkg.sv
// e_calc_pkg
//   Shared types for the e_calc fixed-point exponential approximator.
//   word_t    : one 16-bit limb of a multiprecision value
//   mp_t      : default-size multiprecision value (WORDS_DEF limbs, limb 0 least significant)
//   state_e   : top-level sequencing FSM states
//   sq_state_e: squarer internal states
package e_calc_pkg;

  localparam int WORD_W    = 16;
  localparam int WORDS_DEF = 32;

  typedef logic [WORD_W-1:0] word_t;
  typedef word_t mp_t [WORDS_DEF];

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_INIT     = 3'd1,
    ST_SQ_START = 3'd2,
    ST_SQ_WAIT  = 3'd3,
    ST_FINISH   = 3'd4
  } state_e;

  typedef enum logic [1:0] {
    SQ_IDLE  = 2'd0,
    SQ_MAC   = 2'd1,
    SQ_SHIFT = 2'd2
  } sq_state_e;

endpackage

// File: rtl/e_calc_squarer.sv
// squarer
//   Sequential multiprecision squarer for unsigned fixed point with one
//   integer limb (limb WORDS-1) and WORDS-1 fraction limbs.
//   One 16x16 partial product per cycle in schoolbook order (row i, column j)
//   is added into a full-width 2*WORDS-limb accumulator, so every carry is
//   resolved exactly. The product is then shifted right by 16*(WORDS-1) bits,
//   truncated to WORDS limbs and held in an output buffer.
// Ports
//   clk, rst_n : clock, async active-low reset
//   start      : one-cycle request; operand captured from in[] on this edge
//   done       : one-cycle pulse, out[] valid from this cycle until next done
//   in[WORDS]  : operand, limb 0 least significant
//   out[WORDS] : truncated square
module squarer
  import e_calc_pkg::*;
#(
  parameter int WORDS = 32
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  start,
  output logic  done,
  input  word_t in  [WORDS],
  output word_t out [WORDS]
);

  localparam int IW   = $clog2(WORDS);
  localparam int ACCW = 2 * WORDS * WORD_W;

  sq_state_e         r_state;
  word_t             r_a   [WORDS];
  logic [ACCW-1:0]   r_acc;
  logic [IW-1:0]     r_i;
  logic [IW-1:0]     r_j;
  word_t             r_out [WORDS];
  logic              r_done;

  logic [31:0]       w_prod;
  logic [IW:0]       w_pos;
  logic [IW+4:0]     w_sh;
  logic [ACCW-1:0]   w_pp;

  assign w_prod = 32'(r_a[r_i]) * 32'(r_a[r_j]);
  assign w_pos  = {1'b0, r_i} + {1'b0, r_j};
  // partial product a[i]*a[j] lands at limb i+j
  assign w_sh   = {w_pos, 4'b0000};
  assign w_pp   = ACCW'(w_prod) << w_sh;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= SQ_IDLE;
      r_acc   <= '0;
      r_i     <= '0;
      r_j     <= '0;
      r_done  <= 1'b0;
      for (int k = 0; k < WORDS; k++) begin
        r_a[k]   <= '0;
        r_out[k] <= '0;
      end
    end else begin
      r_done <= 1'b0;
      case (r_state)
        SQ_IDLE: begin
          if (start) begin
            r_a     <= in;
            r_acc   <= '0;
            r_i     <= '0;
            r_j     <= '0;
            r_state <= SQ_MAC;
          end
        end
        SQ_MAC: begin
          r_acc <= r_acc + w_pp;
          if (r_j == IW'(WORDS-1)) begin
            r_j <= '0;
            if (r_i == IW'(WORDS-1)) r_state <= SQ_SHIFT;
            else                     r_i     <= r_i + 1'b1;
          end else begin
            r_j <= r_j + 1'b1;
          end
        end
        SQ_SHIFT: begin
          // drop the low WORDS-1 limbs (truncation), keep the next WORDS limbs
          for (int k = 0; k < WORDS; k++)
            r_out[k] <= r_acc[WORD_W*(WORDS-1) + WORD_W*k +: WORD_W];
          r_done  <= 1'b1;
          r_state <= SQ_IDLE;
        end
        default: r_state <= SQ_IDLE;
      endcase
    end
  end

  assign done = r_done;
  assign out  = r_out;

endmodule

// File: rtl/e_calc.sv
// e_calc
//   Computes (1 + 1/N)^N ~ e in unsigned fixed point by loading 1 + 2^-LOG2_N
//   and squaring it LOG2_N times with the sequential squarer.
//   result[WORDS-1] is the integer limb, result[WORDS-2] the top fraction limb.
// Ports
//   clk, rst_n     : clock, async active-low reset
//   start          : one-cycle request, accepted only in IDLE
//   done           : high while result holds a completed value; cleared on
//                    the edge after the next accepted start
//   result[0:WORDS-1] : final value, updated only in FINISH
//
//   state       | meaning
//   ST_IDLE     | waiting for start
//   ST_INIT     | load 1 + 2^-LOG2_N, clear squaring counter
//   ST_SQ_START | pulse squarer start with current working value
//   ST_SQ_WAIT  | wait for squarer done, take its output, count it
//   ST_FINISH   | copy working value to result, raise done
module e_calc
  import e_calc_pkg::*;
#(
  parameter int WORDS  = 32,
  parameter int N      = 32768,
  parameter int LOG2_N = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        done,
  output logic [15:0] result [0:WORDS-1]
);

  localparam int CW   = $clog2(LOG2_N + 1);
  localparam int FBIT = WORD_W*(WORDS-1) - LOG2_N;
  localparam int FW   = FBIT / WORD_W;
  localparam int FB   = FBIT % WORD_W;

  state_e        r_state;
  logic [CW-1:0] r_cnt;
  word_t         r_work   [WORDS];
  word_t         r_result [WORDS];
  logic          r_done;

  word_t         w_init   [WORDS];
  word_t         w_sq_out [WORDS];
  logic          w_sq_start;
  logic          w_sq_done;

  // 1 + 2^-LOG2_N in the working format (N is 2**LOG2_N)
  always_comb begin
    for (int k = 0; k < WORDS; k++) w_init[k] = '0;
    w_init[WORDS-1]  = 16'h0001;
    w_init[FW][FB]   = 1'b1;
  end

  assign w_sq_start = (r_state == ST_SQ_START);

  squarer #(.WORDS(WORDS)) u_squarer (
    .clk   (clk),
    .rst_n (rst_n),
    .start (w_sq_start),
    .done  (w_sq_done),
    .in    (r_work),
    .out   (w_sq_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_done  <= 1'b0;
      for (int k = 0; k < WORDS; k++) begin
        r_work[k]   <= '0;
        r_result[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_done  <= 1'b0;
            r_state <= ST_INIT;
          end
        end
        ST_INIT: begin
          r_work  <= w_init;
          r_cnt   <= '0;
          r_state <= ST_SQ_START;
        end
        ST_SQ_START: r_state <= ST_SQ_WAIT;
        ST_SQ_WAIT: begin
          if (w_sq_done) begin
            r_work <= w_sq_out;
            r_cnt  <= r_cnt + 1'b1;
            if (int'(r_cnt) + 1 < LOG2_N) r_state <= ST_SQ_START;
            else                          r_state <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          r_result <= r_work;
          r_done   <= 1'b1;
          r_state  <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign done = r_done;

  always_comb begin
    for (int k = 0; k < WORDS; k++) result[k] = r_result[k];
  end

endmodule

// File: tb/tb_e_calc.sv
module tb_e_calc;

  localparam int WORDS   = 32;
  localparam int BOUND_A = 15*(WORDS*WORDS + 2*WORDS + 8) + 8;
  localparam int BOUND_B = 1*(WORDS*WORDS + 2*WORDS + 8) + 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        done_a, done_b;
  logic [15:0] result_a [0:WORDS-1];
  logic [15:0] result_b [0:WORDS-1];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  e_calc #(.WORDS(WORDS), .N(32768), .LOG2_N(15)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .done(done_a), .result(result_a)
  );

  e_calc #(.WORDS(WORDS), .N(2), .LOG2_N(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .done(done_b), .result(result_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero_a(input string tag);
    logic [15:0] acc;
    acc = '0;
    for (int k = 0; k < WORDS; k++) acc = acc | result_a[k];
    chk({tag, "_done"}, {31'd0, done_a}, 32'd0);
    chk({tag, "_result_or"}, {16'd0, acc}, 32'd0);
  endtask

  // start pulse on DUT A, wait for done; optional second start mid-run
  task automatic run_a(input string tag, input bit extra, output int lat);
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    lat = 1;
    chk({tag, "_done_fall"}, {31'd0, done_a}, 32'd0);
    while (!done_a && lat < BOUND_A) begin
      start_a = (extra && (lat == 100 || lat == 5000));
      @(negedge clk);
      lat++;
    end
    start_a = 1'b0;
    chk({tag, "_timeout"}, {31'd0, done_a}, 32'd1);
    chk({tag, "_lat_bound"}, {31'd0, (lat <= BOUND_A)}, 32'd1);
    chk({tag, "_w31"}, {16'd0, result_a[31]}, 32'h0002);
    chk({tag, "_w30"}, {16'd0, result_a[30]}, 32'hB7DE);
  endtask

  initial begin
    int lat_a, lat_c, lat_d, lat_e, lat_b;
    logic [15:0] save [WORDS];

    // reset
    repeat (2) @(negedge clk);
    chk_zero_a("rst_a");
    chk("rst_b_done", {31'd0, done_b}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // LOG2_N=1: (1.5)^2 = 2.25
    @(negedge clk) start_b = 1'b1;
    @(negedge clk) start_b = 1'b0;
    lat_b = 1;
    while (!done_b && lat_b < BOUND_B) begin
      @(negedge clk);
      lat_b++;
    end
    chk("small_timeout", {31'd0, done_b}, 32'd1);
    for (int k = 0; k < WORDS; k++) begin
      logic [15:0] e;
      e = (k == 31) ? 16'h0002 : (k == 30) ? 16'h4000 : 16'h0000;
      chk($sformatf("small_w%0d", k), {16'd0, result_b[k]}, {16'd0, e});
    end

    // default run
    run_a("run1", 1'b0, lat_a);
    for (int k = 0; k < WORDS; k++) save[k] = result_a[k];

    // back-to-back run: result must hold previous value until FINISH
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    chk("run2_done_fall", {31'd0, done_a}, 32'd0);
    chk("run2_hold_w30", {16'd0, result_a[30]}, 32'hB7DE);
    lat_c = 1;
    while (!done_a && lat_c < BOUND_A) begin
      @(negedge clk);
      lat_c++;
    end
    chk("run2_timeout", {31'd0, done_a}, 32'd1);
    chk("run2_lat_same", lat_c, lat_a);
    for (int k = 0; k < WORDS; k++)
      chk($sformatf("run2_same_w%0d", k), {16'd0, result_a[k]}, {16'd0, save[k]});

    // start pulses while busy are ignored
    run_a("busy", 1'b1, lat_d);
    chk("busy_lat_same", lat_d, lat_a);
    repeat (3) @(negedge clk);
    chk("busy_no_restart", {31'd0, done_a}, 32'd1);

    // reset mid-run
    @(negedge clk) start_a = 1'b1;
    @(negedge clk) start_a = 1'b0;
    repeat (500) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero_a("abort_during");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero_a("abort_after");
    repeat (20) @(negedge clk);
    chk_zero_a("abort_idle");
    run_a("rerun", 1'b0, lat_e);
    chk("rerun_lat_same", lat_e, lat_a);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
